// File: rtl/red_pitaya_pid_out_stage.sv
// PID output conditioning: offset with saturation, [min,max] clamp, slew limiter,
// and debounced/sticky rail flags that feed PID anti-windup.
module red_pitaya_pid_out_stage #(
   parameter int DW        = 14,
   parameter int SLEW_BITS = 14,
   parameter int RDLY_BITS = 16
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic [DW-1:0]        dat_i,
   input  logic [DW-1:0]        set_offset_i,
   input  logic [DW-1:0]        set_min_i,
   input  logic [DW-1:0]        set_max_i,
   input  logic [SLEW_BITS-1:0] set_slew_i,
   input  logic [RDLY_BITS-1:0] set_rdly_i,
   input  logic                 freeze_i,
   input  logic                 sticky_clr_i,
   output logic [DW-1:0]        dat_o,
   output logic [1:0]           railed_o,
   output logic [1:0]           rail_sticky_o,
   output logic                 cfg_err_o
);

   localparam int SW = ((DW > SLEW_BITS) ? DW : SLEW_BITS) + 2;

   function automatic logic signed [DW-1:0] sat_add(input logic signed [DW-1:0] a,
                                                    input logic signed [DW-1:0] b);
      logic signed [DW:0] sum;
      sum = {a[DW-1], a} + {b[DW-1], b};
      if (sum[DW] != sum[DW-1])
         sat_add = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      else
         sat_add = sum[DW-1:0];
   endfunction

   logic signed [DW-1:0]  s1_r;
   logic signed [DW-1:0]  t_r;
   logic signed [DW-1:0]  y_r;
   logic [1:0]            pin_r;
   logic                  cfg_err_r;
   logic [RDLY_BITS-1:0]  cnt_r [2];
   logic [1:0]            railed_r;
   logic [1:0]            sticky_r;

   logic signed [DW-1:0]  min_s, max_s, lo_s, hi_s, t_s, y_nx_s;
   logic                  cfg_err_s;
   logic [1:0]            pin_s;
   logic signed [SW-1:0]  t_x_s, y_x_s, slew_x_s, diff_s, step_s;
   logic [RDLY_BITS-1:0]  cnt_nx_s [2];
   logic [1:0]            railed_nx_s, sticky_nx_s;

   // S2 clamp: an inverted window collapses to lo=hi=min
   always_comb begin
      min_s     = $signed(set_min_i);
      max_s     = $signed(set_max_i);
      cfg_err_s = (min_s > max_s);
      lo_s      = min_s;
      hi_s      = cfg_err_s ? min_s : max_s;
      if (s1_r > hi_s)
         t_s = hi_s;
      else if (s1_r < lo_s)
         t_s = lo_s;
      else
         t_s = s1_r;
      pin_s[1] = (s1_r >= hi_s);
      pin_s[0] = (s1_r <= lo_s);
   end

   // S3 slew limiter; a step never passes t so the result fits DW bits
   always_comb begin
      t_x_s    = {{(SW-DW){t_r[DW-1]}}, t_r};
      y_x_s    = {{(SW-DW){y_r[DW-1]}}, y_r};
      slew_x_s = $signed({{(SW-SLEW_BITS){1'b0}}, set_slew_i});
      diff_s   = t_x_s - y_x_s;
      step_s   = t_x_s;
      if (freeze_i)
         step_s = y_x_s;
      else if (set_slew_i == {SLEW_BITS{1'b0}})
         step_s = t_x_s;
      else if (diff_s > slew_x_s)
         step_s = y_x_s + slew_x_s;
      else if (diff_s < -slew_x_s)
         step_s = y_x_s - slew_x_s;
      else
         step_s = t_x_s;
      y_nx_s = step_s[DW-1:0];
   end

   // rail debounce counters and sticky flags
   always_comb begin
      for (int k = 0; k < 2; k++) begin
         if (!pin_r[k])
            cnt_nx_s[k] = {RDLY_BITS{1'b0}};
         else if (cnt_r[k] == {RDLY_BITS{1'b1}})
            cnt_nx_s[k] = cnt_r[k];
         else
            cnt_nx_s[k] = cnt_r[k] + {{(RDLY_BITS-1){1'b0}}, 1'b1};
         railed_nx_s[k] = pin_r[k] && (cnt_r[k] >= set_rdly_i);
         sticky_nx_s[k] = railed_nx_s[k] | (sticky_r[k] & ~(sticky_clr_i & ~railed_r[k]));
      end
   end

   // pipeline and flag registers
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         s1_r      <= {DW{1'b0}};
         t_r       <= {DW{1'b0}};
         y_r       <= {DW{1'b0}};
         pin_r     <= 2'b00;
         cfg_err_r <= 1'b0;
         cnt_r[0]  <= {RDLY_BITS{1'b0}};
         cnt_r[1]  <= {RDLY_BITS{1'b0}};
         railed_r  <= 2'b00;
         sticky_r  <= 2'b00;
      end else begin
         s1_r      <= sat_add($signed(dat_i), $signed(set_offset_i));
         t_r       <= t_s;
         y_r       <= y_nx_s;
         pin_r     <= pin_s;
         cfg_err_r <= cfg_err_s;
         cnt_r[0]  <= cnt_nx_s[0];
         cnt_r[1]  <= cnt_nx_s[1];
         railed_r  <= railed_nx_s;
         sticky_r  <= sticky_nx_s;
      end
   end

   assign dat_o         = y_r;
   assign railed_o      = railed_r;
   assign rail_sticky_o = sticky_r;
   assign cfg_err_o     = cfg_err_r;

endmodule

// File: tb/tb_red_pitaya_pid_out_stage.sv
// Directed bench: steady-state vector table plus rail, slew, freeze, cfg and reset sequences.
module tb_red_pitaya_pid_out_stage;

   logic               clk_i = 1'b0;
   logic               rstn_i;
   logic signed [13:0] dat_i, set_offset_i, set_min_i, set_max_i;
   logic [13:0]        set_slew_i;
   logic [15:0]        set_rdly_i;
   logic               freeze_i, sticky_clr_i;
   logic signed [13:0] dat_o;
   logic [1:0]         railed_o, rail_sticky_o;
   logic               cfg_err_o;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int dat; int off; int mn; int mx;
      int exp_dat; int exp_rail; int exp_cfg;
   } vec_t;
   vec_t vecs [8];

   red_pitaya_pid_out_stage dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .dat_i(dat_i), .set_offset_i(set_offset_i),
      .set_min_i(set_min_i), .set_max_i(set_max_i), .set_slew_i(set_slew_i),
      .set_rdly_i(set_rdly_i), .freeze_i(freeze_i), .sticky_clr_i(sticky_clr_i),
      .dat_o(dat_o), .railed_o(railed_o), .rail_sticky_o(rail_sticky_o),
      .cfg_err_o(cfg_err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   initial begin
      vecs[0] = '{1000,     0, -8192, 8191,  1000, 0, 0};
      vecs[1] = '{8000,   500, -8192, 8191,  8191, 2, 0};
      vecs[2] = '{-8000, -500, -8192, 8191, -8192, 1, 0};
      vecs[3] = '{8191,  8191, -8192, 8191,  8191, 2, 0};
      vecs[4] = '{3000,     0, -1000, 2000,  2000, 2, 0};
      vecs[5] = '{-5000,    0, -1000, 2000, -1000, 1, 0};
      vecs[6] = '{100,   -300, -8192, 8191,  -200, 0, 0};
      vecs[7] = '{0,        0,   100, -100,   100, 1, 1};

      rstn_i = 1'b0; dat_i = 14'sd0; set_offset_i = 14'sd0;
      set_min_i = -14'sd8192; set_max_i = 14'sd8191;
      set_slew_i = 14'd0; set_rdly_i = 16'd0; freeze_i = 1'b0; sticky_clr_i = 1'b0;
      tick(2);
      chk("reset dat_o", int'(dat_o), 0);
      chk("reset railed_o", int'(railed_o), 0);
      chk("reset sticky", int'(rail_sticky_o), 0);
      chk("reset cfg_err", int'(cfg_err_o), 0);
      @(negedge clk_i);
      rstn_i = 1'b1;
      tick(1);

      // steady-state table, limiter bypassed, rdly=0
      for (int v = 0; v < 8; v++) begin
         dat_i = 14'(vecs[v].dat); set_offset_i = 14'(vecs[v].off);
         set_min_i = 14'(vecs[v].mn); set_max_i = 14'(vecs[v].mx);
         tick(4);
         chk($sformatf("vec%0d dat_o", v), int'(dat_o), vecs[v].exp_dat);
         chk($sformatf("vec%0d railed_o", v), int'(railed_o), vecs[v].exp_rail);
         chk($sformatf("vec%0d cfg_err", v), int'(cfg_err_o), vecs[v].exp_cfg);
      end

      // clamp and rail debounce timing, rdly=4
      dat_i = 14'sd0; set_offset_i = 14'sd0; set_min_i = -14'sd1000; set_max_i = 14'sd2000;
      set_rdly_i = 16'd4;
      tick(6);
      sticky_clr_i = 1'b1; tick(1); sticky_clr_i = 1'b0;
      chk("sticky cleared pre-rail", int'(rail_sticky_o), 0);
      dat_i = 14'sd3000;
      for (int i = 1; i <= 9; i++) begin
         tick(1);
         if (i == 3) chk("clamp dat_o", int'(dat_o), 2000);
         chk($sformatf("rail rise t%0d", i), int'(railed_o[1]), (i >= 7) ? 1 : 0);
         if (i == 8) chk("sticky after rise", int'(rail_sticky_o[1]), 1);
      end
      dat_i = 14'sd0;
      for (int i = 1; i <= 4; i++) begin
         tick(1);
         chk($sformatf("rail fall t%0d", i), int'(railed_o[1]), (i < 3) ? 1 : 0);
         if (i == 3) chk("unclamp dat_o", int'(dat_o), 0);
      end
      chk("sticky holds", int'(rail_sticky_o[1]), 1);
      sticky_clr_i = 1'b1; tick(1); sticky_clr_i = 1'b0;
      chk("sticky clr", int'(rail_sticky_o), 0);

      // slew ramp up and down
      set_min_i = -14'sd8192; set_max_i = 14'sd8191; set_rdly_i = 16'd0;
      tick(4);
      set_slew_i = 14'd100; dat_i = 14'sd1050;
      for (int i = 1; i <= 14; i++) begin
         tick(1);
         if (i >= 3) chk($sformatf("slew up t%0d", i), int'(dat_o), (100*(i-2) < 1050) ? 100*(i-2) : 1050);
      end
      dat_i = -14'sd50;
      for (int i = 1; i <= 14; i++) begin
         tick(1);
         if (i >= 3) chk($sformatf("slew dn t%0d", i), int'(dat_o), (1050-100*(i-2) > -50) ? 1050-100*(i-2) : -50);
      end

      // freeze mid-ramp, rail keeps tracking demand
      set_slew_i = 14'd0; dat_i = 14'sd0;
      tick(4);
      set_slew_i = 14'd100; dat_i = 14'sd1050;
      tick(7);
      chk("ramp at 500", int'(dat_o), 500);
      freeze_i = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick(1);
         chk($sformatf("frozen t%0d", i), int'(dat_o), 500);
      end
      dat_i = 14'sd8000; set_offset_i = 14'sd500;
      tick(3);
      chk("frozen railed", int'(railed_o), 2);
      chk("frozen dat_o", int'(dat_o), 500);
      freeze_i = 1'b0;
      tick(1);
      chk("resume 600", int'(dat_o), 600);
      tick(1);
      chk("resume 700", int'(dat_o), 700);

      // inverted limits
      set_slew_i = 14'd0; set_offset_i = 14'sd0; dat_i = 14'sd100;
      set_min_i = 14'sd100; set_max_i = -14'sd100;
      tick(4);
      chk("cfg dat_o", int'(dat_o), 100);
      chk("cfg railed", int'(railed_o), 3);
      chk("cfg_err", int'(cfg_err_o), 1);

      // asynchronous reset mid-cycle
      set_min_i = -14'sd8191; set_max_i = 14'sd8191; dat_i = 14'sd1000;
      tick(4);
      chk("pre-reset dat_o", int'(dat_o), 1000);
      chk("pre-reset sticky", int'(rail_sticky_o), 3);
      @(posedge clk_i);
      #3 rstn_i = 1'b0;
      #1;
      chk("async rst dat_o", int'(dat_o), 0);
      chk("async rst railed", int'(railed_o), 0);
      chk("async rst sticky", int'(rail_sticky_o), 0);
      @(negedge clk_i);
      rstn_i = 1'b1;
      tick(2);
      chk("post-rst 2clk", int'(dat_o), 0);
      tick(1);
      chk("post-rst 3clk", int'(dat_o), 1000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
